// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, state and class definitions for the CPU sequencer
package cpu_defs_pkg;

  localparam logic [5:0] OPC_NOP   = 6'd0;
  localparam logic [5:0] OPC_ADD   = 6'd1;
  localparam logic [5:0] OPC_LOAD  = 6'd2;
  localparam logic [5:0] OPC_STORE = 6'd3;
  localparam logic [5:0] OPC_SUB   = 6'd4;
  localparam logic [5:0] OPC_AND   = 6'd5;
  localparam logic [5:0] OPC_OR    = 6'd6;
  localparam logic [5:0] OPC_XOR   = 6'd7;
  localparam logic [5:0] OPC_SLL   = 6'd8;
  localparam logic [5:0] OPC_SRL   = 6'd9;
  localparam logic [5:0] OPC_SRA   = 6'd10;
  localparam logic [5:0] OPC_SLT   = 6'd11;
  localparam logic [5:0] OPC_SLTU  = 6'd12;
  localparam logic [5:0] OPC_MUL   = 6'd13;
  localparam logic [5:0] OPC_ADDI  = 6'd14;
  localparam logic [5:0] OPC_ANDI  = 6'd15;
  localparam logic [5:0] OPC_ORI   = 6'd16;
  localparam logic [5:0] OPC_XORI  = 6'd17;
  localparam logic [5:0] OPC_LUI   = 6'd18;
  localparam logic [5:0] OPC_SLTI  = 6'd19;
  localparam logic [5:0] OPC_MOV   = 6'd20;
  localparam logic [5:0] OPC_JUMP  = 6'd21;
  localparam logic [5:0] OPC_BRA   = 6'd22;
  localparam logic [5:0] OPC_LAST  = 6'b010110;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef struct packed {
    logic is_legal;
    logic is_mem;
    logic is_store;
    logic is_ctrl;
    logic needs_wb;
    logic src_sel;
  } opc_class_t;

endpackage

// File: rtl/opc_classify.sv
// rtl/opc_classify.sv - combinational opcode classifier shared by the sequencer and operand mux
module opc_classify
  import cpu_defs_pkg::*;
(
  input  logic [5:0]  opc_i,
  output opc_class_t  cls_o
);

  always_comb begin
    cls_o          = '0;
    cls_o.is_legal = (opc_i <= OPC_LAST);
    cls_o.is_store = (opc_i == OPC_STORE);
    cls_o.is_mem   = (opc_i == OPC_LOAD) || (opc_i == OPC_STORE);
    cls_o.is_ctrl  = (opc_i == OPC_NOP) || (opc_i == OPC_JUMP) || (opc_i == OPC_BRA);
    // LOAD writes back after its memory phase; STORE and control ops never do
    cls_o.needs_wb = cls_o.is_legal && !cls_o.is_ctrl && !cls_o.is_store;
    cls_o.src_sel  = cls_o.is_store;
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with timeout and retire count
module cpu_seq_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      instr_in,
  input  logic             mem_ack,
  input  logic             cond_flag,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [5:0]       opc_out,
  output logic             src_sel,
  output logic             alu_start,
  output logic             rf_we,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       opc_q, opc_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             req_c, we_c, irl_c, inc_c, pcl_c, alu_c, rfw_c;
  opc_class_t       cls;
  logic             unused_instr;

  assign unused_instr = ^instr_in[25:0];

  opc_classify u_cls (
    .opc_i (opc_q),
    .cls_o (cls)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    timer_d = '0;
    fault_d = fault_q;
    retire  = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    irl_c   = 1'b0;
    inc_c   = 1'b0;
    pcl_c   = 1'b0;
    alu_c   = 1'b0;
    rfw_c   = 1'b0;
    case (state_q)
      ST_FETCH, ST_MEM: begin
        req_c = 1'b1;
        we_c  = (state_q == ST_MEM) && cls.is_store;
        // an ack on the expiry cycle still wins over the timeout
        if (mem_ack) begin
          if (state_q == ST_FETCH) begin
            irl_c   = 1'b1;
            opc_d   = instr_in[31:26];
            state_d = ST_DECODE;
          end else if (cls.needs_wb) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (timer_q == T_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DECODE: begin
        inc_c = 1'b1;
        if (cls.is_legal) begin
          state_d = ST_EXEC;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        if (cls.is_ctrl) begin
          alu_c   = (opc_q == OPC_BRA);
          pcl_c   = (opc_q == OPC_JUMP) || ((opc_q == OPC_BRA) && cond_flag);
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          alu_c   = 1'b1;
          state_d = cls.is_mem ? ST_MEM : ST_WB;
        end
      end
      ST_WB: begin
        rfw_c   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        fault_d = 1'b1;
        state_d = ST_FAULT;
      end
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      opc_q   <= OPC_NOP;
      timer_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // pulses and handshake are forced low while reset is held
  assign mem_req     = req_c & reset_n;
  assign mem_we      = we_c  & reset_n;
  assign ir_load     = irl_c & reset_n;
  assign pc_inc      = inc_c & reset_n;
  assign pc_load     = pcl_c & reset_n;
  assign alu_start   = alu_c & reset_n;
  assign rf_we       = rfw_c & reset_n;
  assign opc_out     = opc_q;
  assign src_sel     = cls.src_sel;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - directed self-checking bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instr_in;
  logic        mem_ack;
  logic        cond_flag;
  logic        mem_req, mem_we, ir_load, pc_inc, pc_load;
  logic [5:0]  opc_out;
  logic        src_sel, alu_start, rf_we, fault;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  cpu_seq_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_in    (instr_in),
    .mem_ack     (mem_ack),
    .cond_flag   (cond_flag),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .opc_out     (opc_out),
    .src_sel     (src_sel),
    .alu_start   (alu_start),
    .rf_we       (rf_we),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    mem_ack  = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic fetch(input logic [5:0] opc);
    instr_in = {opc, 26'h155_5555};
    mem_ack  = 1'b1;
    settle();
    chk("fetch_ir_load", 32'(ir_load), 1);
    chk("fetch_mem_req", 32'(mem_req), 1);
    chk("fetch_mem_we",  32'(mem_we),  0);
    cyc();
    mem_ack = 1'b0;
    settle();
    chk("decode_pc_inc", 32'(pc_inc), 1);
    chk("decode_opc",    32'(opc_out), 32'(opc));
  endtask

  initial begin
    reset_n   = 1'b0;
    instr_in  = 32'h0;
    mem_ack   = 1'b1;
    cond_flag = 1'b0;
    cyc();
    settle();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_load", 32'(ir_load), 0);
    chk("rst_opc",     32'(opc_out), 0);
    chk("rst_count",   instr_count,  0);
    chk("rst_fault",   32'(fault),   0);
    mem_ack = 1'b0;
    cyc();
    reset_n = 1'b1;

    // ADD, ack in first FETCH cycle
    fetch(6'd1);
    cyc();
    chk("add_alu_start", 32'(alu_start), 1);
    chk("add_src_sel",   32'(src_sel),   0);
    chk("add_exec_rfwe", 32'(rf_we),     0);
    cyc();
    chk("add_rf_we",     32'(rf_we),     1);
    chk("add_cnt_pre",   instr_count,    0);
    cyc();
    chk("add_cnt",       instr_count,    1);
    chk("add_back_fetch", 32'(mem_req),  1);

    // STORE with two MEM wait cycles
    fetch(6'd3);
    cyc();
    chk("st_alu_start", 32'(alu_start), 1);
    chk("st_src_exec",  32'(src_sel),   1);
    chk("st_we_exec",   32'(mem_we),    0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("st_wait_req", 32'(mem_req), 1);
      chk("st_wait_we",  32'(mem_we),  1);
      chk("st_wait_src", 32'(src_sel), 1);
      chk("st_wait_cnt", instr_count,  1);
    end
    cyc();
    mem_ack = 1'b1;
    settle();
    chk("st_ack_we",   32'(mem_we), 1);
    chk("st_ack_rfwe", 32'(rf_we),  0);
    cyc();
    mem_ack = 1'b0;
    settle();
    chk("st_cnt",      instr_count,  2);
    chk("st_fetch_we", 32'(mem_we),  0);
    chk("st_fetch_rq", 32'(mem_req), 1);

    // BRA taken, then not taken
    fetch(6'd22);
    cyc();
    cond_flag = 1'b1;
    settle();
    chk("bra1_pc_load", 32'(pc_load),   1);
    chk("bra1_alu",     32'(alu_start), 1);
    cyc();
    cond_flag = 1'b0;
    chk("bra1_cnt",     instr_count,    3);
    chk("bra1_fetch",   32'(mem_req),   1);
    fetch(6'd22);
    cyc();
    chk("bra0_pc_load", 32'(pc_load),   0);
    cyc();
    chk("bra0_cnt",     instr_count,    4);

    // JUMP and NOP
    fetch(6'd21);
    cyc();
    chk("jmp_pc_load", 32'(pc_load),   1);
    chk("jmp_alu",     32'(alu_start), 0);
    cyc();
    chk("jmp_cnt",     instr_count,    5);
    fetch(6'd0);
    cyc();
    chk("nop_alu",     32'(alu_start), 0);
    chk("nop_pc_load", 32'(pc_load),   0);
    cyc();
    chk("nop_cnt",     instr_count,    6);

    // reset during MEM of a LOAD
    fetch(6'd2);
    cyc();
    cyc();
    chk("ld_mem_req", 32'(mem_req), 1);
    chk("ld_mem_we",  32'(mem_we),  0);
    reset_n = 1'b0;
    mem_ack = 1'b1;
    settle();
    chk("ldrst_req",  32'(mem_req), 0);
    chk("ldrst_rfwe", 32'(rf_we),   0);
    cyc();
    chk("ldrst_opc",  32'(opc_out), 0);
    chk("ldrst_cnt",  instr_count,  0);
    chk("ldrst_req2", 32'(mem_req), 0);
    chk("ldrst_rfw2", 32'(rf_we),   0);
    cyc();
    reset_n = 1'b1;
    mem_ack = 1'b0;
    settle();
    chk("ldrst_fetch", 32'(mem_req), 1);
    chk("ldrst_rfw3",  32'(rf_we),   0);

    // FETCH timeout: no ack for 16 cycles, late ack ignored
    for (int i = 0; i < 16; i++) begin
      chk("to_fault_lo", 32'(fault),   0);
      chk("to_req",      32'(mem_req), 1);
      cyc();
    end
    chk("to_fault",   32'(fault),   1);
    chk("to_req_off", 32'(mem_req), 0);
    instr_in = {6'd1, 26'h0};
    mem_ack  = 1'b1;
    settle();
    chk("to_late_irl", 32'(ir_load), 0);
    cyc();
    mem_ack = 1'b0;
    chk("to_late_opc", 32'(opc_out), 0);
    chk("to_sticky",   32'(fault),   1);

    // ack on the expiry cycle counts as success
    do_reset();
    for (int i = 0; i < 15; i++) cyc();
    fetch(6'd1);
    chk("edge_fault", 32'(fault), 0);

    // illegal opcodes: just above OPC_LAST and all-ones
    for (int k = 0; k < 2; k++) begin
      do_reset();
      fetch(k == 0 ? 6'd23 : 6'h3f);
      cyc();
      for (int i = 0; i < 20; i++) begin
        chk("ill_fault", 32'(fault),   1);
        chk("ill_req",   32'(mem_req), 0);
        chk("ill_cnt",   instr_count,  0);
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
